// File: rtl/sim_test_monitor.sv
// sim_test_monitor: test-completion monitor for the PipelinedCPU bench/FPGA.
// Snoops data-memory stores to the riscv-tests "tohost" word and the retire
// strobe. It reports PASS/FAIL, a watchdog TIMEOUT or a pipeline HANG as sticky
// flags, and keeps saturating cycle and retire counters while the test runs.
// Optional console capture is enabled by defining SIM_TEST_MONITOR_CONSOLE_EN.
// The console captures byte stores to CONSOLE_ADDR while the monitor is running.
module sim_test_monitor #(
  parameter int unsigned       XLEN           = 32,
  parameter int unsigned       ALEN           = 32,
  parameter logic [ALEN-1:0]   TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned       TIMEOUT_CYCLES = 100_000,
  parameter int unsigned       HANG_CYCLES    = 1_024,
  parameter int unsigned       CNT_W          = 32
`ifdef SIM_TEST_MONITOR_CONSOLE_EN
  , parameter logic [ALEN-1:0] CONSOLE_ADDR   = 32'h0000_1004
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ALEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_we,
  input  logic [3:0]       dmem_be,
  input  logic             retire,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             hang,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count,
  output logic             console_valid,
  output logic [7:0]       console_char
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam bit               HANG_EN      = (HANG_CYCLES != 32'd0);
  // The "-1" values are only consulted when the matching enable is set.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HANG_LAST    = CNT_W'(HANG_CYCLES - 32'd1);
  localparam logic [XLEN-1:0]  PASS_VALUE   = XLEN'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic             tohost_hit_s;
  logic             term_hit_s;
  logic             timeout_s;
  logic             hang_s;
  logic             done_r;
  logic             pass_r;
  logic             fail_r;
  logic             timeout_r;
  logic             hang_r;
  logic [XLEN-1:0]  fail_code_r;
  logic [CNT_W-1:0] cycle_count_r;
  logic [CNT_W-1:0] retire_count_r;
  logic [CNT_W-1:0] idle_r;

  // Full-word store to tohost; only odd values end the test, even ones are syscalls.
  assign tohost_hit_s = dmem_we && (dmem_be == 4'hF) && (dmem_addr == TOHOST_ADDR);
  assign term_hit_s   = tohost_hit_s && dmem_wdata[0];
  assign timeout_s    = TIMEOUT_EN && (cycle_count_r == TIMEOUT_LAST);
  assign hang_s       = HANG_EN && !retire && (idle_r == HANG_LAST);

  // State register: RUN after reset, terminal states hold until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode with priority tohost hit > watchdog > hang.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (term_hit_s) begin
          if (dmem_wdata == PASS_VALUE) begin
            state_next_s = ST_PASS;
          end else begin
            state_next_s = ST_FAIL;
          end
        end else if (timeout_s) begin
          state_next_s = ST_TIMEOUT;
        end else if (hang_s) begin
          state_next_s = ST_HANG;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG: begin
        state_next_s = state_r;
      end
      default: begin
        state_next_s = ST_RUN;
      end
    endcase
  end

  // Registered status flags, taken from the next state so they rise on the deciding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timeout_r   <= 1'b0;
      hang_r      <= 1'b0;
      fail_code_r <= '0;
    end else begin
      done_r    <= (state_next_s != ST_RUN);
      pass_r    <= (state_next_s == ST_PASS);
      fail_r    <= (state_next_s == ST_FAIL);
      timeout_r <= (state_next_s == ST_TIMEOUT);
      hang_r    <= (state_next_s == ST_HANG);
      if ((state_r == ST_RUN) && (state_next_s == ST_FAIL)) begin
        fail_code_r <= {1'b0, dmem_wdata[XLEN-1:1]};
      end
    end
  end

  // RUN-time counters: cycles, retires and retire silence, all saturating and frozen once terminal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count_r  <= '0;
      retire_count_r <= '0;
      idle_r         <= '0;
    end else if (state_r == ST_RUN) begin
      if (cycle_count_r != CNT_MAX) begin
        cycle_count_r <= cycle_count_r + CNT_ONE;
      end
      if (retire && (retire_count_r != CNT_MAX)) begin
        retire_count_r <= retire_count_r + CNT_ONE;
      end
      if (retire) begin
        idle_r <= '0;
      end else if (idle_r != CNT_MAX) begin
        idle_r <= idle_r + CNT_ONE;
      end
    end
  end

  assign done         = done_r;
  assign pass         = pass_r;
  assign fail         = fail_r;
  assign timeout      = timeout_r;
  assign hang         = hang_r;
  assign fail_code    = fail_code_r;
  assign cycle_count  = cycle_count_r;
  assign retire_count = retire_count_r;

`ifdef SIM_TEST_MONITOR_CONSOLE_EN
  logic       console_hit_s;
  logic       console_valid_r;
  logic [7:0] console_char_r;

  assign console_hit_s = (state_r == ST_RUN) && dmem_we && dmem_be[0] &&
                         (dmem_addr == CONSOLE_ADDR);

  // Console byte capture: one-cycle valid pulse per byte store while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      console_valid_r <= 1'b0;
      console_char_r  <= 8'h00;
    end else begin
      console_valid_r <= console_hit_s;
      if (console_hit_s) begin
        console_char_r <= dmem_wdata[7:0];
`ifndef SYNTHESIS
        $write("%c", dmem_wdata[7:0]);
`endif
      end
    end
  end

  assign console_valid = console_valid_r;
  assign console_char  = console_char_r;
`else
  assign console_valid = 1'b0;
  assign console_char  = 8'h00;
`endif

endmodule

// File: tb/tb_sim_test_monitor.sv
// Self-checking bench for sim_test_monitor: directed scenarios plus randomized
// runs compared against a behavioural model of the completion rules.
module tb_sim_test_monitor;

  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam logic [31:0] CONSOLE = 32'h0000_1004;
  localparam int          TMO     = 200;
  localparam int          HNG     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_we = 1'b0;
  logic [3:0]  dmem_be = '0;
  logic        retire = 1'b0;
  logic        done, pass, fail, timeout, hang;
  logic [31:0] fail_code, cycle_count, retire_count;
  logic        console_valid;
  logic [7:0]  console_char;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_pass, m_fail, m_tmo, m_hang, m_cvalid;
  logic [31:0] m_code;
  logic [7:0]  m_cchar;
  int          m_cycles, m_retires, m_silence;

  always #5 clk = ~clk;

  sim_test_monitor #(
    .XLEN(32), .ALEN(32), .TOHOST_ADDR(TOHOST),
    .TIMEOUT_CYCLES(TMO), .HANG_CYCLES(HNG), .CNT_W(32)
`ifdef SIM_TEST_MONITOR_CONSOLE_EN
    , .CONSOLE_ADDR(CONSOLE)
`endif
  ) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .retire(retire),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .hang(hang),
    .fail_code(fail_code), .cycle_count(cycle_count), .retire_count(retire_count),
    .console_valid(console_valid), .console_char(console_char)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pass = 0; m_fail = 0; m_tmo = 0; m_hang = 0; m_cvalid = 0;
    m_code = '0; m_cchar = '0; m_cycles = 0; m_retires = 0; m_silence = 0;
  endtask

  // Apply the monitor's rules for one clock edge with the given bus inputs.
  task automatic model_edge(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input bit ret);
    bit running;
    running = !(m_pass || m_fail || m_tmo || m_hang);
    m_cvalid = 0;
`ifdef SIM_TEST_MONITOR_CONSOLE_EN
    if (running && we && be[0] && addr == CONSOLE) begin
      m_cvalid = 1;
      m_cchar  = wd[7:0];
    end
`endif
    if (running) begin
      m_cycles++;
      if (ret) m_retires++;
      m_silence = ret ? 0 : m_silence + 1;
      if (we && be == 4'hF && addr == TOHOST && wd[0]) begin
        if (wd == 32'd1) m_pass = 1;
        else begin
          m_fail = 1;
          m_code = wd / 2;
        end
      end else if (m_cycles == TMO) m_tmo = 1;
      else if (m_silence == HNG) m_hang = 1;
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_done"}, done, m_pass | m_fail | m_tmo | m_hang);
    chk({tag, "_pass"}, pass, m_pass);
    chk({tag, "_fail"}, fail, m_fail);
    chk({tag, "_timeout"}, timeout, m_tmo);
    chk({tag, "_hang"}, hang, m_hang);
    chk({tag, "_fail_code"}, fail_code, m_code);
    chk({tag, "_cycles"}, cycle_count, m_cycles);
    chk({tag, "_retires"}, retire_count, m_retires);
    chk({tag, "_cvalid"}, console_valid, m_cvalid);
    chk({tag, "_cchar"}, console_char, m_cchar);
  endtask

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic step(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input bit ret);
    dmem_we = we; dmem_addr = addr; dmem_wdata = wd; dmem_be = be; retire = ret;
    @(posedge clk);
    model_edge(we, addr, wd, be, ret);
    @(negedge clk);
    dmem_we = 1'b0; retire = 1'b0;
  endtask

  task automatic idle(input int n, input bit ret);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0, ret);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #2;
    chk_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit          we, ret;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    int          quiet, r;

    model_reset();
    @(negedge clk);

    // 1: pass on the 50th RUN cycle
    do_reset("t1_rst");
    idle(49, 1'b1);
    chk("t1_pre_done", done, 0);
    step(1'b1, TOHOST, 32'h1, 4'hF, 1'b1);
    chk("t1_pass", pass, 1);
    chk("t1_done", done, 1);
    chk("t1_cycles", cycle_count, 50);
    chk("t1_retires", retire_count, 50);
    idle(5, 1'b1);
    chk("t1_frozen", cycle_count, 50);
    chk_all("t1");

    // 2: fail with code, later pass store ignored
    do_reset("t2_rst");
    idle(7, 1'b1);
    step(1'b1, TOHOST, 32'h0000_0007, 4'hF, 1'b1);
    chk("t2_fail", fail, 1);
    chk("t2_code", fail_code, 3);
    idle(3, 1'b1);
    step(1'b1, TOHOST, 32'h1, 4'hF, 1'b1);
    chk("t2_pass_stays0", pass, 0);
    chk("t2_code_kept", fail_code, 3);
    chk_all("t2");

    // 3: watchdog after exactly TMO cycles
    do_reset("t3_rst");
    idle(TMO - 1, 1'b1);
    chk("t3_not_yet", timeout, 0);
    idle(1, 1'b1);
    chk("t3_timeout", timeout, 1);
    chk("t3_cycles", cycle_count, TMO);
    idle(5, 1'b1);
    chk("t3_frozen", cycle_count, TMO);
    chk_all("t3");

    // 4: hang 16 cycles after last retire, deferred by a late retire
    do_reset("t4a_rst");
    idle(40, 1'b1);
    idle(15, 1'b0);
    chk("t4a_not_yet", hang, 0);
    idle(1, 1'b0);
    chk("t4a_hang", hang, 1);
    chk_all("t4a");
    do_reset("t4b_rst");
    idle(40, 1'b1);
    idle(14, 1'b0);
    idle(1, 1'b1);
    idle(15, 1'b0);
    chk("t4b_not_yet", hang, 0);
    idle(1, 1'b0);
    chk("t4b_hang", hang, 1);
    chk("t4b_retires", retire_count, 41);
    chk_all("t4b");

    // 5: hit coincident with watchdog expiry wins; byte store and even value ignored
    do_reset("t5_rst");
    for (int c = 1; c < TMO; c++) begin
      if (c == 10) step(1'b1, TOHOST, 32'h1, 4'h1, 1'b1);
      else if (c == 20) step(1'b1, TOHOST, 32'h2, 4'hF, 1'b1);
      else step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    end
    chk("t5_still_run", done, 0);
    step(1'b1, TOHOST, 32'h1, 4'hF, 1'b1);
    chk("t5_pass", pass, 1);
    chk("t5_timeout", timeout, 0);
    chk_all("t5");

    // 6: asynchronous reset mid-run, then console byte
    do_reset("t6_rst");
    idle(29, 1'b1);
    chk("t6_cycles_pre", cycle_count, 29);
    #2 rst = 1'b1;
    #1;
    chk("t6_cycles_async", cycle_count, 0);
    chk("t6_retires_async", retire_count, 0);
    model_reset();
    chk_all("t6_async");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, CONSOLE, 32'h0000_0041, 4'h1, 1'b1);
`ifdef SIM_TEST_MONITOR_CONSOLE_EN
    chk("t6_cvalid", console_valid, 1);
    chk("t6_cchar", console_char, 8'h41);
`else
    chk("t6_cvalid", console_valid, 0);
    chk("t6_cchar", console_char, 0);
`endif
    idle(1, 1'b1);
    chk("t6_cvalid_pulse", console_valid, 0);
    chk_all("t6");

    // Randomized runs against the model
    for (int run = 0; run < 6; run++) begin
      do_reset("rnd_rst");
      quiet = 0;
      for (int c = 0; c < 260; c++) begin
        we = ($urandom % 3) == 0;
        r  = $urandom % 4;
        addr = (r < 2) ? TOHOST : (r == 2) ? CONSOLE : (32'h0000_2000 + ($urandom % 64) * 4);
        r  = $urandom % 4;
        be = (r < 2) ? 4'hF : (r == 2) ? 4'h1 : 4'h3;
        if (($urandom % 8) == 0) wd = (($urandom % 2) == 0) ? 32'h1 : ($urandom | 32'h1);
        else wd = $urandom & 32'hFFFF_FFFE;
        if (addr == CONSOLE) wd[7:0] = 8'h61 + 8'($urandom % 26);
        if (quiet == 0 && ($urandom % 40) == 0) quiet = 20;
        if (quiet > 0) begin
          ret = 1'b0;
          quiet--;
        end else begin
          ret = ($urandom % 8) != 0;
        end
        step(we, addr, wd, be, ret);
        chk_all("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
